mem_burst_reader: RTL and testbench

Read initiator for a single-port memory core: combinational read data, synchronous write. Accepts a burst request (start address, length) on a valid/ready handshake, walks consecutive memory addresses and streams the read elements out on a valid/ready stream, flagging the final element. It sits between a memory core's address/read-data port and any stream consumer (DMA, serializer, checker). Writes are out of scope; the memory write enable is owned elsewhere.

---
 rtl/mem_pkg.sv | 9 +
 rtl/mem_burst_reader_fifo.sv | 50 +++++
 rtl/mem_burst_reader.sv | 86 ++++++++
 tb/tb_mem_burst_reader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the burst read initiator.
package mem_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } mem_rd_state_e;

endpackage

// File: rtl/mem_burst_reader_fifo.sv
// Two-entry FIFO holding fetched beats until the stream consumer takes them.
module fifo_2 #(
  parameter int Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage is cleared too so the head reads zero after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read initiator: walks consecutive addresses of a combinational-read
// memory and streams the elements out, marking the final beat of each burst.
module mem_burst_reader
  import mem_pkg::*;
#(
  parameter int ElemWidth = 8,
  parameter int AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [AddrWidth-1:0] req_len_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic [ElemWidth-1:0] mem_rdata_i,
  output logic [ElemWidth-1:0] data_o,
  output logic                 data_last_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 busy_o
);

  mem_rd_state_e        state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [AddrWidth-1:0] rem_q;
  logic [1:0]           count;
  logic                 fetch;
  logic                 pop;
  logic                 last_fetch;
  logic [ElemWidth:0]   head;

  // Fetch looks only at the registered fill level, keeping data_ready_i
  // off the address/fetch path.
  assign fetch      = (state_q == READ) && (count != 2'd2);
  assign last_fetch = (rem_q == '0);
  assign pop        = data_valid_o && data_ready_i;

  assign req_ready_o  = (state_q == IDLE);
  assign mem_addr_o   = addr_q;
  assign data_valid_o = (count != 2'd0);
  assign data_o       = head[ElemWidth:1];
  assign data_last_o  = head[0];
  assign busy_o       = (state_q == READ) || (count != 2'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            rem_q   <= req_len_i;
            state_q <= READ;
          end
        end
        READ: begin
          if (fetch) begin
            addr_q <= addr_q + AddrWidth'(1);
            rem_q  <= rem_q - AddrWidth'(1);
            if (last_fetch) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fifo_2 #(
    .Width(ElemWidth + 1)
  ) u_out_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fetch),
    .push_data_i ({mem_rdata_i, last_fetch}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed and randomized bench for mem_burst_reader with a queue-based model.
module tb_mem_burst_reader;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] req_addr_i;
  logic [7:0] req_len_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [7:0] mem_addr_o;
  logic [7:0] mem_rdata_i;
  logic [7:0] data_o;
  logic       data_last_o;
  logic       data_valid_o;
  logic       data_ready_i;
  logic       busy_o;

  logic [7:0] mem [256];
  logic [8:0] exp_q [$];
  logic [8:0] mon_exp;
  int checks   = 0;
  int failures = 0;
  int beats    = 0;
  bit rnd_ready = 1'b0;

  always #5 clk_i = ~clk_i;

  assign mem_rdata_i = mem[mem_addr_o];

  mem_burst_reader #(.ElemWidth(8), .AddrWidth(8)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_addr_i   (req_addr_i),
    .req_len_i    (req_len_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .data_o       (data_o),
    .data_last_o  (data_last_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .busy_o       (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every beat handed over must match the next expected element.
  always @(negedge clk_i) begin
    if (!rst_i && data_valid_o && data_ready_i) begin
      chk("beat_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        chk("beat_data_last", {data_o, data_last_o}, mon_exp);
      end
      beats++;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    if (rnd_ready) data_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send_req(input logic [7:0] a, input logic [7:0] l);
    int w = 0;
    for (int i = 0; i <= int'(l); i++)
      exp_q.push_back({mem[8'(int'(a) + i)], (i == int'(l))});
    req_addr_i  = a;
    req_len_i   = l;
    req_valid_i = 1'b1;
    while (!req_ready_o && w < 500) begin
      step();
      w++;
    end
    chk("req_ready_timeout", (w < 500), 1);
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((busy_o || exp_q.size() != 0) && w < 2000) begin
      step();
      w++;
    end
    chk("drain_timeout", (w < 2000), 1);
  endtask

  initial begin
    logic [7:0] seq_d [4];
    int b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_len_i = '0;
    data_ready_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_last", data_last_o, 0);
    chk("rst_valid", data_valid_o, 0);
    chk("rst_busy", busy_o, 0);

    // Basic burst with exact latency
    send_req(8'h10, 8'd3);
    chk("t1_addr", mem_addr_o, 8'h10);
    chk("t1_ready_low", req_ready_o, 0);
    chk("t1_valid_n", data_valid_o, 0);
    seq_d = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_valid", data_valid_o, 1);
      chk("t1_data", data_o, seq_d[k]);
      chk("t1_last", data_last_o, (k == 3));
    end
    chk("t1_ready_back", req_ready_o, 1);
    step();
    chk("t1_idle_valid", data_valid_o, 0);
    chk("t1_idle_busy", busy_o, 0);

    // Address wrap
    send_req(8'hFE, 8'd3);
    seq_d = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_data", data_o, seq_d[k]);
      chk("t2_last", data_last_o, (k == 3));
      if (k == 1) chk("t2_wrap_addr", mem_addr_o, 8'h00);
    end
    wait_drain();

    // Single-element burst
    send_req(8'h40, 8'd0);
    step();
    chk("t3_valid", data_valid_o, 1);
    chk("t3_data", data_o, 8'hE5);
    chk("t3_last", data_last_o, 1);
    chk("t3_ready", req_ready_o, 1);
    step();
    chk("t3_done", data_valid_o, 0);

    // Backpressure: 1 cycle ready, 2 cycles not
    data_ready_i = 1'b0;
    b0 = beats;
    send_req(8'h00, 8'd7);
    for (int c = 0; c < 60 && (busy_o || exp_q.size() != 0); c++) begin
      data_ready_i = (c % 3 == 0);
      step();
      chk("t4_fetch_bound", (int'(mem_addr_o) <= (beats - b0) + 2), 1);
    end
    data_ready_i = 1'b1;
    wait_drain();
    chk("t4_beat_count", beats - b0, 8);

    // Back-to-back requests while draining
    b0 = beats;
    send_req(8'h20, 8'd1);
    send_req(8'h80, 8'd1);
    wait_drain();
    chk("t5_beat_count", beats - b0, 4);

    // Reset mid-burst
    send_req(8'h30, 8'd9);
    step();
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    exp_q.delete();
    chk("t6_valid", data_valid_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_ready", req_ready_o, 1);
    chk("t6_addr", mem_addr_o, 0);
    step();
    chk("t6_still_idle", busy_o, 0);
    send_req(8'h10, 8'd0);
    step();
    chk("t6_after_data", data_o, 8'hB5);
    chk("t6_after_last", data_last_o, 1);
    wait_drain();

    // Randomized bursts with random backpressure
    rnd_ready = 1'b1;
    for (int it = 0; it < 30; it++) begin
      if (it % 3 == 0) begin
        wait_drain();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      end
      send_req(8'($urandom), 8'($urandom_range(0, 20)));
    end
    wait_drain();
    rnd_ready = 1'b0;
    data_ready_i = 1'b1;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
